ab_seq_tx: RTL and testbench

Transmit-side counterpart of the two-line A/B sequence detector. On a start request it drives a programmable sequence of N single-cycle symbols onto the `a_out`/`b_out` lines: symbol A = (1,0), symbol B = (0,1), idle = (0,0). Idle gaps separate the symbols, so a level-sampling detector advances exactly one state per symbol. It sits in the stimulus/test-harness path and connects directly to the detector's `a`/`b` inputs.

---
 rtl/ab_seq_pkg.sv | 17 +
 rtl/ab_seq_tx.sv | 104 ++++++++++
 tb/tb_ab_seq_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ab_seq_pkg.sv
// Shared A/B line definitions used by the sequence transmitter and detector.
package ab_seq_pkg;

    // Line symbols in {a,b} order
    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_A    = 2'b10;
    localparam logic [1:0] SYM_B    = 2'b01;

    // Default detect pattern, bit 0 first: A,B,A,A
    localparam logic [3:0] DET_PAT = 4'b1101;

    // Map one pattern bit to its line symbol (1 = A, 0 = B)
    function automatic logic [1:0] sym_of(input logic bit_a);
        return bit_a ? SYM_A : SYM_B;
    endfunction

endpackage

// File: rtl/ab_seq_tx.sv
// A/B sequence transmitter: drives N single-cycle symbols onto a_out/b_out,
// each followed by GAP idle cycles, so a level-sampling detector advances
// exactly one state per symbol.
module ab_seq_tx
    import ab_seq_pkg::*;
#(
    parameter int N   = 4,
    parameter int GAP = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] pat,
    output logic         a_out,
    output logic         b_out,
    output logic         busy,
    output logic         done
);

    localparam int IW = (N > 1)   ? $clog2(N)   : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   pat_q;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_nxt;
    logic [GW-1:0]  gcnt;

    // Index of the symbol that follows the current one
    always_comb begin
        idx_nxt = idx + 1'b1;
    end

    // Sequencer FSM with registered line, busy and done outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            pat_q          <= '0;
            idx            <= '0;
            gcnt           <= '0;
            {a_out, b_out} <= SYM_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    {a_out, b_out} <= SYM_IDLE;
                    busy           <= 1'b0;
                    if (start) begin
                        pat_q          <= pat;
                        idx            <= '0;
                        {a_out, b_out} <= sym_of(pat[0]);
                        busy           <= 1'b1;
                        state          <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    {a_out, b_out} <= SYM_IDLE;
                    gcnt           <= GAP_LOAD;
                    state          <= S_GAP;
                end
                S_GAP: begin
                    if (gcnt != '0) begin
                        gcnt <= gcnt - 1'b1;
                    end else if (idx != IDX_LAST) begin
                        idx            <= idx_nxt;
                        {a_out, b_out} <= sym_of(pat_q[idx_nxt]);
                        state          <= S_DRIVE;
                    end else begin
                        done <= 1'b1;
                        // A start sampled on the final gap edge is accepted
                        // directly so back-to-back sequences have no idle cycle
                        // and busy stays high across them.
                        if (start) begin
                            pat_q          <= pat;
                            idx            <= '0;
                            {a_out, b_out} <= sym_of(pat[0]);
                            state          <= S_DRIVE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    {a_out, b_out} <= SYM_IDLE;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ab_seq_tx.sv
// Bench for ab_seq_tx: per-cycle scoreboard of {a_out,b_out,busy,done} plus
// a free-running line monitor (no 11, symbols one cycle wide).
module tb_ab_seq_tx;

    localparam int N = 4;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic         start3 = 1'b0;
    logic [N-1:0] pat    = '0;

    logic a0, b0, busy0, done0;
    logic a1, b1, busy1, done1;
    logic a3, b3, busy3, done3;

    always #5 clk = ~clk;

    ab_seq_tx #(.N(N), .GAP(2)) dut (
        .clk(clk), .resetn(resetn), .start(start0), .pat(pat),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0)
    );

    ab_seq_tx #(.N(N), .GAP(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .pat(pat),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1)
    );

    ab_seq_tx #(.N(N), .GAP(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start3), .pat(pat),
        .a_out(a3), .b_out(b3), .busy(busy3), .done(done3)
    );

    int          tests = 0;
    int          fails = 0;
    int          sel   = 0;
    string       tag   = "none";
    logic [3:0]  exp_q[$];

    function automatic logic [3:0] obs_of(input int s);
        case (s)
            0:       return {a0, b0, busy0, done0};
            1:       return {a1, b1, busy1, done1};
            default: return {a3, b3, busy3, done3};
        endcase
    endfunction

    task automatic check(input string t, input logic [3:0] o, input logic [3:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    // Expected per-cycle vectors for one sequence accepted at the next edge
    task automatic push_seq(input logic [N-1:0] p, input int g, input logic first_done);
        logic [1:0] l;
        for (int j = 0; j < N * (1 + g); j++) begin
            if (j % (1 + g) == 0) l = p[j / (1 + g)] ? 2'b10 : 2'b01;
            else                  l = 2'b00;
            exp_q.push_back({l, 1'b1, (j == 0) ? first_done : 1'b0});
        end
    endtask

    task automatic push_end();
        exp_q.push_back(4'b0001);
    endtask

    task automatic push_idle(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(4'b0000);
    endtask

    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty observed=%b expected=entry", tag, obs_of(sel));
        end else begin
            e = exp_q.pop_front();
            check(tag, obs_of(sel), e);
        end
    endtask

    // Line monitor: never 11, and a symbol is always followed by idle
    logic [1:0] prev0 = 2'b00, prev1 = 2'b00, prev3 = 2'b00;
    always @(negedge clk) begin
        tests++;
        assert (!(a0 && b0) && !(a1 && b1) && !(a3 && b3)) else begin
            fails++;
            $error("FAIL illegal_11 observed=%b%b/%b%b/%b%b expected=no 11", a0, b0, a1, b1, a3, b3);
        end
        if (prev0 != 2'b00 || prev1 != 2'b00 || prev3 != 2'b00) begin
            tests++;
            assert ((prev0 == 2'b00 || {a0, b0} == 2'b00) &&
                    (prev1 == 2'b00 || {a1, b1} == 2'b00) &&
                    (prev3 == 2'b00 || {a3, b3} == 2'b00)) else begin
                fails++;
                $error("FAIL symbol_width observed=%b%b/%b%b/%b%b expected=00 after symbol",
                       a0, b0, a1, b1, a3, b3);
            end
        end
        prev0 <= {a0, b0};
        prev1 <= {a1, b1};
        prev3 <= {a3, b3};
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_gap2", obs_of(0), 4'b0000);
        check("reset_gap1", obs_of(1), 4'b0000);
        check("reset_gap3", obs_of(2), 4'b0000);
        resetn = 1'b1;
        @(negedge clk);

        // Default pattern 1101; pat changed mid-sequence must have no effect
        sel = 0; tag = "default_1101";
        pat = 4'b1101; start0 = 1'b1;
        push_seq(4'b1101, 2, 1'b0); push_end();
        tick();
        start0 = 1'b0; pat = 4'b0000;
        repeat (12) tick();
        push_idle(2);
        repeat (2) tick();

        // All-B pattern
        tag = "all_b";
        pat = 4'b0000; start0 = 1'b1;
        push_seq(4'b0000, 2, 1'b0); push_end();
        tick();
        start0 = 1'b0;
        repeat (12) tick();
        push_idle(1);
        tick();

        // Start while busy at cycle 5 is ignored
        tag = "start_busy";
        pat = 4'b1101; start0 = 1'b1;
        push_seq(4'b1101, 2, 1'b0); push_end();
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        start0 = 1'b1; pat = 4'b0000;
        tick();
        start0 = 1'b0; pat = 4'b1101;
        repeat (7) tick();
        push_idle(2);
        repeat (2) tick();

        // Reset during symbol 2
        tag = "reset_mid";
        pat = 4'b1101; start0 = 1'b1;
        push_seq(4'b1101, 2, 1'b0); push_end();
        tick();
        start0 = 1'b0;
        repeat (6) tick();
        #2 resetn = 1'b0;
        #1 check("reset_async", obs_of(0), 4'b0000);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        tag = "after_reset";
        push_idle(3);
        repeat (3) tick();

        // GAP=3 timing
        sel = 2; tag = "gap3_1011";
        pat = 4'b1011; start3 = 1'b1;
        push_seq(4'b1011, 3, 1'b0); push_end();
        tick();
        start3 = 1'b0;
        repeat (16) tick();

        // Back-to-back with start held high, GAP=1
        sel = 1; tag = "back_to_back";
        pat = 4'b0110; start1 = 1'b1;
        push_seq(4'b0110, 1, 1'b0); push_seq(4'b1001, 1, 1'b1); push_end();
        tick();
        pat = 4'b1001;
        repeat (15) tick();
        start1 = 1'b0;
        tick();
        push_idle(2);
        repeat (2) tick();

        // Random start timing and patterns on GAP=1 and GAP=3, monitor active
        repeat (1000) begin
            @(negedge clk);
            start1 = ($urandom_range(0, 3) == 0);
            start3 = ($urandom_range(0, 3) == 0);
            pat    = 4'($urandom);
        end
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        repeat (20) @(negedge clk);
        check("rand_idle_gap1", obs_of(1), 4'b0000);
        check("rand_idle_gap3", obs_of(2), 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
